// File: rtl/csp_split_router.sv
// csp_split_router: clocked 1-to-2 demultiplexer for a 4-phase bundled-data
// channel. A token arriving on the input channel is latched and forwarded on
// out0 or out1 depending on the destination bit travelling with it. Both the
// input-side and output-side handshakes run through the full 4-phase cycle.
module csp_split_router #(
  parameter int width       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  input  logic [width-1:0] in_data,
  input  logic             in_dest,
  output logic             in_ack,
  output logic             out0_req,
  output logic [width-1:0] out0_data,
  input  logic             out0_ack,
  output logic             out1_req,
  output logic [width-1:0] out1_data,
  input  logic             out1_ack,
  output logic             busy,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FWD       = 2'd1,
    WAIT_REL  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] req_sync, ack0_sync, ack1_sync;
  logic                   s_req, s_ack0, s_ack1, s_ack_sel;

  logic                   sel, sel_next;
  logic                   in_ack_next;
  logic                   out0_req_next, out1_req_next;
  logic [width-1:0]       out0_data_next, out1_data_next;
  logic [7:0]             cnt0_next, cnt1_next;

  // Multi-flop synchronizers bring the asynchronous req/ack wires into the
  // clk domain; data and dest are bundled and stable before req, so they are
  // sampled directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_sync  <= '0;
      ack0_sync <= '0;
      ack1_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], in_req};
      ack0_sync <= {ack0_sync[SYNC_STAGES-2:0], out0_ack};
      ack1_sync <= {ack1_sync[SYNC_STAGES-2:0], out1_ack};
    end
  end

  assign s_req     = req_sync[SYNC_STAGES-1];
  assign s_ack0    = ack0_sync[SYNC_STAGES-1];
  assign s_ack1    = ack1_sync[SYNC_STAGES-1];
  // Only the ack of the channel carrying the current token is observed.
  assign s_ack_sel = sel ? s_ack1 : s_ack0;

  assign busy = (state != IDLE);

  // State and all handshake outputs are registered here; reset clears
  // everything immediately so the peers see a quiet channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      in_ack    <= 1'b0;
      out0_req  <= 1'b0;
      out1_req  <= 1'b0;
      out0_data <= '0;
      out1_data <= '0;
      cnt0      <= 8'd0;
      cnt1      <= 8'd0;
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      in_ack    <= in_ack_next;
      out0_req  <= out0_req_next;
      out1_req  <= out1_req_next;
      out0_data <= out0_data_next;
      out1_data <= out1_data_next;
      cnt0      <= cnt0_next;
      cnt1      <= cnt1_next;
    end
  end

  // Next-state and next-output logic: each state waits for one synchronized
  // handshake phase, then advances exactly one phase on the other side. The
  // non-selected output channel is never written.
  always_comb begin
    state_next     = state;
    sel_next       = sel;
    in_ack_next    = in_ack;
    out0_req_next  = out0_req;
    out1_req_next  = out1_req;
    out0_data_next = out0_data;
    out1_data_next = out1_data;
    cnt0_next      = cnt0;
    cnt1_next      = cnt1;

    case (state)
      IDLE: begin
        if (s_req) begin
          sel_next = in_dest;
          if (in_dest) begin
            out1_data_next = in_data;
            out1_req_next  = 1'b1;
          end else begin
            out0_data_next = in_data;
            out0_req_next  = 1'b1;
          end
          state_next = FWD;
        end
      end

      FWD: begin
        if (s_ack_sel) begin
          in_ack_next = 1'b1;
          state_next  = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (!s_req) begin
          if (sel) begin
            out1_req_next = 1'b0;
          end else begin
            out0_req_next = 1'b0;
          end
          state_next = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (!s_ack_sel) begin
          in_ack_next = 1'b0;
          if (sel) begin
            cnt1_next = cnt1 + 8'd1;
          end else begin
            cnt0_next = cnt0 + 8'd1;
          end
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csp_split_router.sv
// Directed bench for csp_split_router: a table of tokens with hand-computed
// counters and output data, plus sequences for reset mid-handshake and
// counter wrap.
module tb_csp_split_router;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  localparam int SIG_OUT0_REQ = 0;
  localparam int SIG_OUT1_REQ = 1;
  localparam int SIG_IN_ACK   = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_req;
  logic [W-1:0] in_data;
  logic         in_dest;
  logic         in_ack;
  logic         out0_req;
  logic [W-1:0] out0_data;
  logic         out0_ack;
  logic         out1_req;
  logic [W-1:0] out1_data;
  logic         out1_ack;
  logic         busy;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  int n_applied = 0;
  int n_miss    = 0;

  typedef struct {
    bit           dest;
    logic [W-1:0] data;
    int           ack_delay;
    bit           spurious;
    logic [7:0]   exp_cnt0;
    logic [7:0]   exp_cnt1;
    logic [W-1:0] exp_out0;
    logic [W-1:0] exp_out1;
  } vec_t;

  vec_t vecs[6];

  csp_split_router #(.width(W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ack    (in_ack),
    .out0_req  (out0_req),
    .out0_data (out0_data),
    .out0_ack  (out0_ack),
    .out1_req  (out1_req),
    .out1_data (out1_data),
    .out1_ack  (out1_ack),
    .busy      (busy),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_applied++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      SIG_OUT0_REQ: probe = out0_req;
      SIG_OUT1_REQ: probe = out1_req;
      default:      probe = in_ack;
    endcase
  endfunction

  // Counts rising clk edges until the probed signal reaches level; -1 on timeout.
  task automatic waitSig(input int which, input logic level, output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (probe(which) === level) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int edges;
    bit bad;
    int req_sig;
    req_sig = v.dest ? SIG_OUT1_REQ : SIG_OUT0_REQ;

    in_data = v.data;
    in_dest = v.dest;
    in_req  = 1'b1;
    waitSig(req_sig, 1'b1, edges);
    checkOutput("req_rise_latency", edges, LAT);
    checkOutput("other_req_quiet", v.dest ? out0_req : out1_req, 0);
    checkOutput("busy_fwd", busy, 1);
    checkOutput("fwd_data", v.dest ? out1_data : out0_data, v.data);

    in_dest = ~v.dest;

    bad = 1'b0;
    for (int i = 0; i < v.ack_delay; i++) begin
      if (v.spurious) begin
        if (v.dest) out0_ack = ((i % 6) < 3);
        else        out1_ack = ((i % 6) < 3);
      end
      @(negedge clk);
      if (in_ack !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      if ((v.dest ? out0_req : out1_req) !== 1'b0) bad = 1'b1;
    end
    if (v.dest) out0_ack = 1'b0;
    else        out1_ack = 1'b0;
    checkOutput("hold_until_sink_ack", bad, 0);

    if (v.dest) out1_ack = 1'b1;
    else        out0_ack = 1'b1;
    waitSig(SIG_IN_ACK, 1'b1, edges);
    checkOutput("in_ack_rise_latency", edges, LAT);

    in_req = 1'b0;
    waitSig(req_sig, 1'b0, edges);
    checkOutput("req_fall_latency", edges, LAT);

    if (v.dest) out1_ack = 1'b0;
    else        out0_ack = 1'b0;
    waitSig(SIG_IN_ACK, 1'b0, edges);
    checkOutput("in_ack_fall_latency", edges, LAT);

    checkOutput("cnt0", cnt0, v.exp_cnt0);
    checkOutput("cnt1", cnt1, v.exp_cnt1);
    checkOutput("busy_idle", busy, 0);
    checkOutput("out0_data_hold", out0_data, v.exp_out0);
    checkOutput("out1_data_hold", out1_data, v.exp_out1);
  endtask

  initial begin
    int   edges;
    vec_t v;

    //          dest data  dly spur  c0     c1     o0     o1
    vecs[0] = '{1'b0, 4'h1, 0,  1'b0, 8'd1, 8'd0, 4'h1, 4'h0};
    vecs[1] = '{1'b1, 4'hA, 2,  1'b0, 8'd1, 8'd1, 4'h1, 4'hA};
    vecs[2] = '{1'b0, 4'h5, 0,  1'b0, 8'd2, 8'd1, 4'h5, 4'hA};
    vecs[3] = '{1'b1, 4'h3, 0,  1'b0, 8'd2, 8'd2, 4'h5, 4'h3};
    vecs[4] = '{1'b1, 4'hC, 20, 1'b0, 8'd2, 8'd3, 4'h5, 4'hC};
    vecs[5] = '{1'b0, 4'h9, 12, 1'b1, 8'd3, 8'd3, 4'h9, 4'hC};

    reset    = 1'b0;
    in_req   = 1'b0;
    in_data  = '0;
    in_dest  = 1'b0;
    out0_ack = 1'b0;
    out1_ack = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_in_ack", in_ack, 0);
    checkOutput("rst_out0_req", out0_req, 0);
    checkOutput("rst_out1_req", out1_req, 0);
    checkOutput("rst_out0_data", out0_data, 0);
    checkOutput("rst_out1_data", out1_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt0", cnt0, 0);
    checkOutput("rst_cnt1", cnt1, 0);

    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset asserted while waiting for the input requester to release.
    in_data = 4'h7;
    in_dest = 1'b0;
    in_req  = 1'b1;
    waitSig(SIG_OUT0_REQ, 1'b1, edges);
    out0_ack = 1'b1;
    waitSig(SIG_IN_ACK, 1'b1, edges);
    checkOutput("midrst_reached_wait_rel", edges, LAT);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_in_ack", in_ack, 0);
    checkOutput("midrst_out0_req", out0_req, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cnt0", cnt0, 0);
    checkOutput("midrst_out0_data", out0_data, 0);
    in_req   = 1'b0;
    out0_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    v = '{1'b0, 4'h6, 0, 1'b0, 8'd1, 8'd0, 4'h6, 4'h0};
    applyStimulus(v);

    // 256 tokens to out1 roll cnt1 through 255 back to 0.
    for (int i = 0; i < 256; i++) begin
      v.dest      = 1'b1;
      v.data      = 4'(i);
      v.ack_delay = 0;
      v.spurious  = 1'b0;
      v.exp_cnt0  = 8'd1;
      v.exp_cnt1  = 8'(i + 1);
      v.exp_out0  = 4'h6;
      v.exp_out1  = 4'(i);
      applyStimulus(v);
    end
    checkOutput("wrap_cnt1_zero", cnt1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/csp_split_router.md
Name: csp_split_router

Overview:
- Clocked demultiplexing responder for one 4-phase bundled-data channel; the complement of the two-input CSP arbiter.
- Accepts one token on the input channel, latches it, and forwards it on out0 or out1 according to a destination bit carried with the token.
- Completes the full 4-phase handshake on both sides.
- Sits at a router output stage between the clocked core and asynchronous neighbour links.

Parameters:
- width, 1, data bits per token (excluding the destination bit).
- SYNC_STAGES, 2, flip-flop stages in each req/ack synchronizer; legal range 2..4.

Ports:
- clk  input  1  single system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_req  input  1  input channel request, 4-phase.
- in_data  input  width  input token data; stable while in_req=1.
- in_dest  input  1  destination select (0 = out0, 1 = out1); stable while in_req=1.
- in_ack  output  1  input channel acknowledge.
- out0_req  output  1  output channel 0 request.
- out0_data  output  width  output channel 0 data.
- out0_ack  input  1  output channel 0 acknowledge.
- out1_req  output  1  output channel 1 request.
- out1_data  output  width  output channel 1 data.
- out1_ack  input  1  output channel 1 acknowledge.
- busy  output  1  high whenever the FSM is not in IDLE.
- cnt0, cnt1  output  8 each  tokens completed on out0/out1, wrap at 255->0.

Behaviour:
- Reset (reset=0, asynchronous): in_ack=0, out0_req=0, out1_req=0, out*_data=0, busy=0, cnt0=cnt1=0, FSM=IDLE, all synchronizer flops=0.
- Reset release is synchronous to the next clk rising edge.
- Synchronization:
  - in_req, out0_ack and out1_ack each pass through SYNC_STAGES flops; the FSM uses only the synchronized versions (s_req, s_ack0, s_ack1).
  - in_data and in_dest are sampled directly. This is safe because they are bundled and stable before in_req rises.
- FSM states and transitions (all outputs registered):
  - IDLE: on s_req=1, latch data into out[dest]_data, latch dest into sel, set out[sel]_req=1, go to FWD.
  - FWD: on s_ack[sel]=1, set in_ack=1, go to WAIT_REL.
  - WAIT_REL: on s_req=0, set out[sel]_req=0, go to WAIT_DONE.
  - WAIT_DONE: on s_ack[sel]=0, set in_ack=0, increment cnt[sel], go to IDLE.
- Latency:
  - in_req rise to out[sel]_req rise = SYNC_STAGES+1 clk edges.
  - Each further handshake phase costs SYNC_STAGES+1 edges.
- Only the selected output channel is touched. The non-selected out_req and out_data hold their values. The ack of the non-selected channel is ignored, including spurious toggles.
- out[sel]_data holds the latched value until the next token for that channel.
- Back-to-back tokens:
  - A new in_req rise is not accepted until the FSM returns to IDLE.
  - A token cannot start before in_ack has fallen, because the 4-phase protocol guarantees in_req=0 at that point.
- Boundaries:
  - cnt wraps 255->0 with no flag.
  - Changes to in_dest after latching have no effect.
  - Reset asserted mid-handshake forces all outputs to 0 immediately. The peer must then restart its protocol.
  - s_req=1 present at reset release is treated as a fresh request.

Test Plan:
- Single token: reset low 2 cycles, then send in_data=1, in_dest=0. Required: out0_req rises 3 edges after in_req, out0_data=1, out1_req stays 0, in_ack=1 after out0_ack, cnt0=1, cnt1=0.
- Alternating destinations: send 4 tokens with dest 0,1,0,1. Required: cnt0=2, cnt1=2, and each out_req pulses only for its matching token.
- Slow sink: out1_ack delayed 20 cycles. Required: in_ack stays 0 and busy=1 throughout; in_ack rises SYNC_STAGES+1 edges after out1_ack.
- Spurious ack: toggle out1_ack during a dest=0 transfer. Required: no state change, and the transfer completes on out0 only.
- Reset mid-handshake: assert reset while in WAIT_REL. Required: in_ack, out0_req and busy go to 0 without waiting for clk, and the next token completes normally with cnt0=1.
- Wrap: send 256 tokens with dest=1. Required: cnt1=0 at the end and no missed handshake.
